// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, instruction memory write port and status bundle for imem_loader
//
// Purpose: groups every non-clock/reset signal of the program loader.
//   master modport : the loader (consumes bytes, drives imem writes and status)
//   slave modport  : the environment (byte source, memory, core reset, host)
// Signals:
//   start        one-cycle pulse that begins a load session
//   rx_data      incoming byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte this cycle
//   imem_we      instruction memory write strobe
//   imem_addr    byte address of the write (always even)
//   imem_wdata   instruction word
//   cpu_hold     holds the core in reset
//   busy         session in progress
//   done         load completed successfully (level)
//   error        load failed (level)
//   words_loaded words written this session

interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [15:0]       imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata,
           cpu_hold, busy, done, error, words_loaded
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
           cpu_hold, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program loader filling instruction memory from a framed byte stream
//
// Purpose: receives SYNC, CNT_HI, CNT_LO, N x (WORD_HI, WORD_LO) [, CSUM] and
//   writes each big-endian word to instruction memory at word_idx<<1, holding
//   the core in reset until a complete, valid image is in place.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    imem_loader_if.master (byte stream in, imem write port and status out)
// Parameters:
//   ADDR_W     word-address bits of instruction memory (capacity 2^ADDR_W words)
//   SYNC_BYTE  frame start marker
// Build option:
//   IMEM_LOADER_CSUM_EN  when defined, the frame ends with an XOR checksum byte
//                        covering the count and word bytes; when undefined there
//                        is no checksum byte and the last word completes the load.

module imem_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  imem_loader_if.master    bus
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

  state_t          state;
  state_t          state_nxt;

  logic [7:0]      cnt_hi;
  logic [15:0]     cnt;
  logic [7:0]      word_hi;
  logic [ADDR_W:0] words_loaded;
  logic            imem_we;
  logic [15:0]     imem_addr;
  logic [15:0]     imem_wdata;

  logic            rx_ready;
  logic            accept;
  logic            session_start;
  logic [15:0]     len_n;
  logic            oversize;
  logic [16:0]     wl_inc;
  logic            last_word;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]      acc;
`endif

  // A session may only be (re)started when no session is running.
  assign session_start = bus.start && (state == IDLE || state == DONE || state == ERR);
  assign accept        = bus.rx_valid && rx_ready;
  assign len_n         = {cnt_hi, bus.rx_data};
  assign oversize      = {1'b0, len_n} > CAPACITY;
  // Word count after the write currently being accepted; last one when it reaches N.
  assign wl_inc        = 17'(words_loaded) + 17'd1;
  assign last_word     = wl_inc >= {1'b0, cnt};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) state_nxt = SYNC;
      end
      SYNC: begin
        rx_ready = 1'b1;
        // Non-marker bytes are line noise before the frame and are dropped.
        if (accept && bus.rx_data == SYNC_BYTE) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (oversize) begin
            state_nxt = ERR;
          end else if (len_n == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        rx_ready = 1'b1;
        if (accept) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
        rx_ready = 1'b1;
        if (accept) state_nxt = (bus.rx_data == acc) ? DONE : ERR;
`else
        state_nxt = ERR;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: count capture, word assembly and the registered write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_hi       <= '0;
      cnt          <= '0;
      word_hi      <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (session_start) begin
        words_loaded <= '0;
      end
      if (accept) begin
        case (state)
          LEN_HI:  cnt_hi  <= bus.rx_data;
          LEN_LO:  cnt     <= len_n;
          DATA_HI: word_hi <= bus.rx_data;
          DATA_LO: begin
            imem_we      <= 1'b1;
            imem_addr    <= 16'({words_loaded, 1'b0});
            imem_wdata   <= {word_hi, bus.rx_data};
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running XOR over count and word bytes; the marker is not included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (session_start) begin
      acc <= '0;
    end else if (accept && (state == LEN_HI || state == LEN_LO ||
                            state == DATA_HI || state == DATA_LO)) begin
      acc <= acc ^ bus.rx_data;
    end
  end
`endif

  assign bus.rx_ready     = rx_ready;
  assign bus.imem_we      = imem_we;
  assign bus.imem_addr    = imem_addr;
  assign bus.imem_wdata   = imem_wdata;
  assign bus.words_loaded = words_loaded;
  assign bus.busy         = (state != IDLE) && (state != DONE) && (state != ERR);
  assign bus.done         = (state == DONE);
  assign bus.error        = (state == ERR);
  // Only a fully loaded and verified image may run.
  assign bus.cpu_hold     = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (directed frames, write scoreboard)

module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.imem_addr, bus.imem_wdata}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("wr_addr", {16'd0, bus.imem_addr}, {16'd0, exp_w[31:16]});
        check("wr_data", {16'd0, bus.imem_wdata}, {16'd0, exp_w[15:0]});
      end
    end
  end

  // Build a frame for the given words and push the writes it must produce.
  task automatic make_frame(input logic [15:0] words[$], input bit bad_csum);
    logic [7:0]  cs;
    logic [15:0] n;
    n = 16'(words.size());
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[15:8]);
    frame_q.push_back(n[7:0]);
    cs = n[15:8] ^ n[7:0];
    for (int i = 0; i < words.size(); i++) begin
      frame_q.push_back(words[i][15:8]);
      frame_q.push_back(words[i][7:0]);
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
      exp_q.push_back({16'(i * 2), words[i]});
    end
`ifdef IMEM_LOADER_CSUM_EN
    frame_q.push_back(bad_csum ? (cs ^ 8'h01) : cs);
`else
    if (bad_csum) frame_q.push_back(cs);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i]);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, {31'd0, bus.cpu_hold}, 32'd1);
    check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    check({tag, "_imem_we"},  {31'd0, bus.imem_we},  32'd0);
    check({tag, "_busy"},     {31'd0, bus.busy},     32'd0);
    check({tag, "_done"},     {31'd0, bus.done},     32'd0);
    check({tag, "_error"},    {31'd0, bus.error},    32'd0);
    check({tag, "_addr"},     {16'd0, bus.imem_addr},  32'd0);
    check({tag, "_wdata"},    {16'd0, bus.imem_wdata}, 32'd0);
    check({tag, "_words"},    32'(bus.words_loaded),   32'd0);
  endtask

  initial begin
    logic [15:0] w[$];

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);

    // Two-word image
    do_start();
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    check("t1_hold", {31'd0, bus.cpu_hold}, 32'd1);
    w = '{16'h1234, 16'hABCD};
    make_frame(w, 1'b0);
    send_frame();
`ifndef IMEM_LOADER_CSUM_EN
    check("t1_done_with_last_we", {30'd0, bus.imem_we, bus.done}, 32'd3);
`endif
    repeat (2) @(negedge clk);
    check("t1_done",  {31'd0, bus.done},     32'd1);
    check("t1_hold_released", {31'd0, bus.cpu_hold}, 32'd0);
    check("t1_words", 32'(bus.words_loaded), 32'd2);
    check("t1_error", {31'd0, bus.error},    32'd0);
    check("t1_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
    // Bad checksum: writes happen, image refused
    do_start();
    check("t2_hold_reasserted", {31'd0, bus.cpu_hold}, 32'd1);
    make_frame(w, 1'b1);
    send_frame();
    check("t2_error", {31'd0, bus.error},    32'd1);
    check("t2_done",  {31'd0, bus.done},     32'd0);
    check("t2_hold",  {31'd0, bus.cpu_hold}, 32'd1);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    // Leading noise discarded, empty image; start while busy ignored
    do_start();
    check("t3_hold_reasserted", {31'd0, bus.cpu_hold}, 32'd1);
    send_byte(8'h00);
    send_byte(8'hFF);
    do_start();
    check("t3_busy_after_restart", {31'd0, bus.busy}, 32'd1);
    w.delete();
    make_frame(w, 1'b0);
    send_frame();
    @(negedge clk);
    check("t3_done",  {31'd0, bus.done}, 32'd1);
    check("t3_words", 32'(bus.words_loaded), 32'd0);

    // Oversize count (257 > 256)
    do_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    check("t4_error",    {31'd0, bus.error},    32'd1);
    check("t4_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("t4_hold",     {31'd0, bus.cpu_hold}, 32'd1);
    bus.rx_data  = 8'h12;
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_rx_ready_later", {31'd0, bus.rx_ready}, 32'd0);
    bus.rx_valid = 1'b0;
    check("t4_words", 32'(bus.words_loaded), 32'd0);

    // Reset mid-frame, then a clean one-word load
    do_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    check("t5_busy_mid", {31'd0, bus.busy}, 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_values("t5_async");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("t5_after");
    do_start();
    w = '{16'hBEEF};
    make_frame(w, 1'b0);
    send_frame();
`ifndef IMEM_LOADER_CSUM_EN
    check("t5_done_with_we", {30'd0, bus.imem_we, bus.done}, 32'd3);
`endif
    @(negedge clk);
    check("t5_done",  {31'd0, bus.done}, 32'd1);
    check("t5_words", 32'(bus.words_loaded), 32'd1);

    // Full-capacity image (N == 2^ADDR_W)
    do_start();
    w.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) w.push_back(16'(i * 16'h0301) ^ 16'h5A3C);
    make_frame(w, 1'b0);
    send_frame();
    @(negedge clk);
    check("t6_done",  {31'd0, bus.done}, 32'd1);
    check("t6_error", {31'd0, bus.error}, 32'd0);
    check("t6_words", 32'(bus.words_loaded), 32'd256);
    check("t6_last_addr", {16'd0, bus.imem_addr}, 32'h0000_01FE);

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
